// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction-fetch unit.
package fetch_unit_pkg;

    localparam int INSTR_SIZE   = 16;
    localparam int PC_SIZE      = 10;
    localparam int OPCODE_SIZE  = 5;
    localparam int TIMEOUT_DFLT = 15;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC and IR, fetches one instruction per request over a
// req/ack handshake with instruction memory, and presents the opcode field.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W    = PC_SIZE,
    parameter int INSTR_W = INSTR_SIZE,
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_req,
    input  logic                   pc_load,
    input  logic [PC_W-1:0]        pc_load_val,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]     imem_rdata,
    input  logic                   imem_ack,
    output logic [INSTR_W-1:0]     ir,
    output logic [OPCODE_SIZE-1:0] opcode,
    output logic                   ir_valid,
    output logic                   busy,
    output logic                   fault,
    output logic [PC_W-1:0]        pc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Handshake: imem_req rises with REQ entry and stays high, with imem_addr
    // frozen, until the cycle imem_ack is sampled; imem_rdata is taken only then.
    fetch_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 pending_q;
    logic [PC_W-1:0]      pend_val_q;
    logic                 timeout_hit;

    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_IDLE: begin
                if (fetch_req)
                    state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (imem_ack)
                    state_d = FETCH_IDLE;
                else if (timeout_hit)
                    state_d = FETCH_FAULT;
            end
            FETCH_FAULT: state_d = FETCH_FAULT;
            default:     state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= FETCH_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= '0;
            ir         <= '0;
            imem_addr  <= '0;
            ir_valid   <= 1'b0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            pend_val_q <= '0;
        end else begin
            ir_valid <= 1'b0;
            unique case (state_q)
                FETCH_IDLE: begin
                    if (pc_load)
                        pc <= pc_load_val;
                    if (fetch_req) begin
                        imem_addr <= pc_load ? pc_load_val : pc;
                        cnt_q     <= '0;
                        pending_q <= 1'b0;
                    end
                end
                FETCH_REQ: begin
                    if (imem_ack) begin
                        ir        <= imem_rdata;
                        ir_valid  <= 1'b1;
                        pending_q <= 1'b0;
                        // A load arriving with the ack is the newest target.
                        if (pc_load)
                            pc <= pc_load_val;
                        else if (pending_q)
                            pc <= pend_val_q;
                        else
                            pc <= imem_addr + 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (pc_load) begin
                            pend_val_q <= pc_load_val;
                            pending_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req = (state_q == FETCH_REQ);
    assign busy     = (state_q == FETCH_REQ);
    assign fault    = (state_q == FETCH_FAULT);
    assign opcode   = ir[INSTR_W-1 -: OPCODE_SIZE];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, PC loads, wrap, timeout fault, reset abort.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic        pc_load;
    logic [9:0]  pc_load_val;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic        ir_valid;
    logic        busy;
    logic        fault;
    logic [9:0]  pc;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .ir(ir), .opcode(opcode),
        .ir_valid(ir_valid), .busy(busy), .fault(fault), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_load_val = '0;
        imem_rdata = '0; imem_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_irv", 32'(ir_valid), 0);

        // Minimum-latency fetch
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        chk("f1_req", 32'(imem_req), 1);
        chk("f1_addr", 32'(imem_addr), 0);
        chk("f1_busy", 32'(busy), 1);
        imem_ack = 1'b1; imem_rdata = 16'h3A05; tick(); imem_ack = 1'b0;
        chk("f1_ir", 32'(ir), 32'h3A05);
        chk("f1_op", 32'(opcode), 32'h07);
        chk("f1_irv", 32'(ir_valid), 1);
        chk("f1_pc", 32'(pc), 1);
        chk("f1_req_low", 32'(imem_req), 0);
        tick();
        chk("f1_irv_pulse", 32'(ir_valid), 0);

        // Ack delayed six cycles
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("f2_req", 32'(imem_req), 1);
            chk("f2_addr", 32'(imem_addr), 1);
            chk("f2_busy", 32'(busy), 1);
            chk("f2_fault", 32'(fault), 0);
            tick();
        end
        imem_ack = 1'b1; imem_rdata = 16'h1234; tick(); imem_ack = 1'b0;
        chk("f2_ir", 32'(ir), 32'h1234);
        chk("f2_pc", 32'(pc), 2);

        // pc_load in IDLE then fetch
        pc_load = 1'b1; pc_load_val = 10'h3F0; tick(); pc_load = 1'b0;
        chk("ld_pc", 32'(pc), 32'h3F0);
        chk("ld_busy", 32'(busy), 0);
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        chk("ld_addr", 32'(imem_addr), 32'h3F0);
        imem_ack = 1'b1; imem_rdata = 16'hF800; tick(); imem_ack = 1'b0;
        chk("ld_pc_inc", 32'(pc), 32'h3F1);
        chk("ld_op", 32'(opcode), 32'h1F);

        // Two loads during REQ: last one wins
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        chk("pend_addr", 32'(imem_addr), 32'h3F1);
        pc_load = 1'b1; pc_load_val = 10'h020; tick();
        pc_load_val = 10'h040; tick(); pc_load = 1'b0;
        chk("pend_addr_hold", 32'(imem_addr), 32'h3F1);
        tick();
        imem_ack = 1'b1; imem_rdata = 16'h0800; tick(); imem_ack = 1'b0;
        chk("pend_pc", 32'(pc), 32'h040);
        chk("pend_op", 32'(opcode), 32'h01);

        // Load with fetch together at 3FF, completion wraps pc to 0
        pc_load = 1'b1; pc_load_val = 10'h3FF; fetch_req = 1'b1; tick();
        pc_load = 1'b0; fetch_req = 1'b0;
        chk("wrap_addr", 32'(imem_addr), 32'h3FF);
        imem_ack = 1'b1; imem_rdata = 16'h5555; tick(); imem_ack = 1'b0;
        chk("wrap_pc", 32'(pc), 0);

        // Reset mid-REQ, late ack ignored
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'hFFFF; tick(); imem_ack = 1'b0;
        chk("abort_ir", 32'(ir), 0);
        chk("abort_irv", 32'(ir_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pc", 32'(pc), 0);

        // Ack in the last allowed cycle beats the timeout
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("edge_busy", 32'(busy), 1);
        imem_ack = 1'b1; imem_rdata = 16'hABCD; tick(); imem_ack = 1'b0;
        chk("edge_fault", 32'(fault), 0);
        chk("edge_irv", 32'(ir_valid), 1);
        chk("edge_pc", 32'(pc), 1);

        // Timeout to FAULT, inputs ignored, reset clears
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("to_pre_fault", 32'(fault), 0);
        chk("to_pre_req", 32'(imem_req), 1);
        tick();
        chk("to_fault", 32'(fault), 1);
        chk("to_req", 32'(imem_req), 0);
        chk("to_busy", 32'(busy), 0);
        fetch_req = 1'b1; pc_load = 1'b1; pc_load_val = 10'h111; tick(); tick();
        fetch_req = 1'b0; pc_load = 1'b0;
        chk("flt_fault", 32'(fault), 1);
        chk("flt_req", 32'(imem_req), 0);
        chk("flt_pc", 32'(pc), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("flt_clr", 32'(fault), 0);
        chk("flt_clr_pc", 32'(pc), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
